// File: rtl/cdma_tile_sequencer.sv
// cdma_tile_sequencer: walks a planes x rows x row_len tile and issues one CDMA
// transfer per row. The source side is strided; the destination side is packed.
// Optional feature macro: CDMA_TIMEOUT_EN adds a per-transfer watchdog that sets
// a sticky error and ends the tile when CDMA_done does not arrive in time.
module cdma_tile_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TRANS_WIDTH = 16,
    parameter int unsigned DIM_WIDTH   = 10
`ifdef CDMA_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_base,
    input  logic [ADDR_WIDTH-1:0]  dst_base,
    input  logic [TRANS_WIDTH-1:0] row_len,
    input  logic [DIM_WIDTH-1:0]   num_rows,
    input  logic [DIM_WIDTH-1:0]   num_planes,
    input  logic [ADDR_WIDTH-1:0]  src_row_stride,
    input  logic [ADDR_WIDTH-1:0]  src_plane_stride,
    output logic [ADDR_WIDTH-1:0]  src_addr,
    output logic [ADDR_WIDTH-1:0]  dst_addr,
    output logic [TRANS_WIDTH-1:0] trans_len,
    output logic                   CDMA_start,
    input  logic                   CDMA_done,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched tile configuration
    logic [TRANS_WIDTH-1:0] row_len_q, row_len_d;
    logic [DIM_WIDTH-1:0]   num_rows_q, num_rows_d;
    logic [DIM_WIDTH-1:0]   num_planes_q, num_planes_d;
    logic [ADDR_WIDTH-1:0]  row_stride_q, row_stride_d;
    logic [ADDR_WIDTH-1:0]  plane_stride_q, plane_stride_d;

    // Walk position
    logic [DIM_WIDTH-1:0]   row_q, row_d;
    logic [DIM_WIDTH-1:0]   plane_q, plane_d;
    logic [ADDR_WIDTH-1:0]  src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0]  plane_ptr_q, plane_ptr_d;
    logic [ADDR_WIDTH-1:0]  dst_ptr_q, dst_ptr_d;

    // Registered outputs
    logic [ADDR_WIDTH-1:0]  src_addr_q, src_addr_d;
    logic [ADDR_WIDTH-1:0]  dst_addr_q, dst_addr_d;
    logic [TRANS_WIDTH-1:0] trans_len_q, trans_len_d;
    logic                   cdma_start_q, cdma_start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ADDR_WIDTH-1:0]  row_bytes;
    logic                   last_row;
    logic                   last_plane;
    logic                   zero_dim;

`ifdef CDMA_TIMEOUT_EN
    localparam int unsigned TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   error_q, error_d;
`endif

    assign row_bytes  = ADDR_WIDTH'(row_len_q) << 2;
    assign last_row   = (row_q == num_rows_q - DIM_WIDTH'(1));
    assign last_plane = (plane_q == num_planes_q - DIM_WIDTH'(1));
    assign zero_dim   = (row_len == '0) || (num_rows == '0) || (num_planes == '0);

    // State, configuration, position and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            row_len_q      <= '0;
            num_rows_q     <= '0;
            num_planes_q   <= '0;
            row_stride_q   <= '0;
            plane_stride_q <= '0;
            row_q          <= '0;
            plane_q        <= '0;
            src_ptr_q      <= '0;
            plane_ptr_q    <= '0;
            dst_ptr_q      <= '0;
            src_addr_q     <= '0;
            dst_addr_q     <= '0;
            trans_len_q    <= '0;
            cdma_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_len_q      <= row_len_d;
            num_rows_q     <= num_rows_d;
            num_planes_q   <= num_planes_d;
            row_stride_q   <= row_stride_d;
            plane_stride_q <= plane_stride_d;
            row_q          <= row_d;
            plane_q        <= plane_d;
            src_ptr_q      <= src_ptr_d;
            plane_ptr_q    <= plane_ptr_d;
            dst_ptr_q      <= dst_ptr_d;
            src_addr_q     <= src_addr_d;
            dst_addr_q     <= dst_addr_d;
            trans_len_q    <= trans_len_d;
            cdma_start_q   <= cdma_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

`ifdef CDMA_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end
`endif

    // Next-state, walk update and next output values
    always_comb begin
        state_d        = state_q;
        row_len_d      = row_len_q;
        num_rows_d     = num_rows_q;
        num_planes_d   = num_planes_q;
        row_stride_d   = row_stride_q;
        plane_stride_d = plane_stride_q;
        row_d          = row_q;
        plane_d        = plane_q;
        src_ptr_d      = src_ptr_q;
        plane_ptr_d    = plane_ptr_q;
        dst_ptr_d      = dst_ptr_q;
        src_addr_d     = src_addr_q;
        dst_addr_d     = dst_addr_q;
        trans_len_d    = trans_len_q;
        cdma_start_d   = 1'b0;
        // done follows FIN by one cycle; busy stays up through that done cycle
        done_d         = (state_q == S_FIN);
        busy_d         = (state_q != S_IDLE);
`ifdef CDMA_TIMEOUT_EN
        timer_d        = timer_q;
        error_d        = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                // busy still high in the cycle after FIN, so a start there is ignored
                if (start && !busy_q) begin
                    row_len_d      = row_len;
                    num_rows_d     = num_rows;
                    num_planes_d   = num_planes;
                    row_stride_d   = src_row_stride;
                    plane_stride_d = src_plane_stride;
                    row_d          = '0;
                    plane_d        = '0;
                    src_ptr_d      = src_base;
                    plane_ptr_d    = src_base;
                    dst_ptr_d      = dst_base;
                    busy_d         = 1'b1;
`ifdef CDMA_TIMEOUT_EN
                    error_d        = 1'b0;
`endif
                    state_d        = zero_dim ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cdma_start_d = 1'b1;
                src_addr_d   = src_ptr_q;
                dst_addr_d   = dst_ptr_q;
                trans_len_d  = row_len_q;
`ifdef CDMA_TIMEOUT_EN
                timer_d      = '0;
`endif
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (CDMA_done) begin
                    state_d = S_NEXT;
                end
`ifdef CDMA_TIMEOUT_EN
                else if (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
`endif
            end
            S_NEXT: begin
                dst_ptr_d = dst_ptr_q + row_bytes;
                if (last_row) begin
                    row_d       = '0;
                    plane_d     = plane_q + DIM_WIDTH'(1);
                    plane_ptr_d = plane_ptr_q + plane_stride_q;
                    src_ptr_d   = plane_ptr_q + plane_stride_q;
                end else begin
                    row_d     = row_q + DIM_WIDTH'(1);
                    src_ptr_d = src_ptr_q + row_stride_q;
                end
                state_d = (last_row && last_plane) ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign src_addr   = src_addr_q;
    assign dst_addr   = dst_addr_q;
    assign trans_len  = trans_len_q;
    assign CDMA_start = cdma_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef CDMA_TIMEOUT_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_cdma_tile_sequencer.sv
// Testbench for cdma_tile_sequencer: a CDMA wrapper responder with programmable
// latency, a monitor recording every transfer, and a loop-based tile model.
module tb_cdma_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic [15:0] row_len = '0;
    logic [9:0]  num_rows = '0;
    logic [9:0]  num_planes = '0;
    logic [31:0] src_row_stride = '0;
    logic [31:0] src_plane_stride = '0;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] trans_len;
    logic        CDMA_start;
    logic        CDMA_done;
    logic        busy;
    logic        done;
    logic        error;

    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;
    assign CDMA_done = resp_done | spur_done;

    int n_cmp = 0;
    int n_bad = 0;

    cdma_tile_sequencer #(
        .ADDR_WIDTH(32),
        .TRANS_WIDTH(16),
        .DIM_WIDTH(10)
`ifdef CDMA_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .src_base(src_base),
        .dst_base(dst_base),
        .row_len(row_len),
        .num_rows(num_rows),
        .num_planes(num_planes),
        .src_row_stride(src_row_stride),
        .src_plane_stride(src_plane_stride),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .trans_len(trans_len),
        .CDMA_start(CDMA_start),
        .CDMA_done(CDMA_done),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Wrapper responder: CDMA_done arrives lat cycles after a CDMA_start
    int lat = 4;
    bit withhold = 1'b0;
    int resp_cnt = 0;
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_done = 1'b1;
            end
            if (CDMA_start && !withhold) resp_cnt = lat;
        end
    end

    // Monitor: cycle counter, transfer log, done and busy accounting
    int          cyc = 0;
    logic [31:0] mon_src[$];
    logic [31:0] mon_dst[$];
    logic [15:0] mon_len[$];
    int          mon_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          busy_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (CDMA_start) begin
            mon_src.push_back(src_addr);
            mon_dst.push_back(dst_addr);
            mon_len.push_back(trans_len);
            mon_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    // Reference tile: row r of plane p reads base + p*plane_stride + r*row_stride
    // and lands at dst_base + (linear row index) * row bytes
    logic [31:0] exp_src[$];
    logic [31:0] exp_dst[$];
    logic [15:0] exp_len[$];

    task automatic build_expected();
        logic [31:0] s;
        logic [31:0] d;
        exp_src.delete();
        exp_dst.delete();
        exp_len.delete();
        if (row_len != 0 && num_rows != 0 && num_planes != 0) begin
            for (int p = 0; p < int'(num_planes); p++) begin
                for (int r = 0; r < int'(num_rows); r++) begin
                    s = src_base + 32'(p) * src_plane_stride + 32'(r) * src_row_stride;
                    d = dst_base + 32'(p * int'(num_rows) + r) * (32'(row_len) * 32'd4);
                    exp_src.push_back(s);
                    exp_dst.push_back(d);
                    exp_len.push_back(row_len);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] sb, input logic [31:0] db, input logic [15:0] rl,
                           input logic [9:0] nr, input logic [9:0] np,
                           input logic [31:0] rs, input logic [31:0] ps);
        src_base         = sb;
        dst_base         = db;
        row_len          = rl;
        num_rows         = nr;
        num_planes       = np;
        src_row_stride   = rs;
        src_plane_stride = ps;
    endtask

    // Drives a one-cycle start; s is the monitor cycle index of that cycle
    task automatic pulse_start(output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int snap, output bit ok);
        int k = 0;
        while (done_cnt == snap && k < 400) begin
            tick();
            k++;
        end
        ok = (done_cnt != snap);
    endtask

    task automatic test_reset();
        logic [84:0] obs;
        repeat (3) @(posedge clk);
        tick();
        obs = {src_addr, dst_addr, trans_len, CDMA_start, busy, done, error};
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || CDMA_start !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b start=%b done=%b expected 0 0 0", busy, CDMA_start, done);
        end
    endtask

    task automatic test_basic_tile();
        int sn, sd, s, n;
        bit ok;
        set_cfg(32'h1000, 32'h8000, 16'd16, 10'd2, 10'd2, 32'h100, 32'h1000);
        lat = 4;
        build_expected();
        // stray CDMA_done in IDLE
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || CDMA_start !== 1'b0) begin
            n_bad++;
            $display("FAIL spur_idle: busy=%b start=%b expected 0 0", busy, CDMA_start);
        end
        sn = mon_src.size();
        sd = done_cnt;
        // stray CDMA_done while in ISSUE
        @(posedge clk); #1; start = 1'b1; s = cyc + 1;
        @(posedge clk); #1; start = 1'b0; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        wait_done(sd, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic_done_timeout: got no done expected done");
        end
        repeat (3) tick();
        n = mon_src.size() - sn;
        n_cmp++;
        if (n != exp_src.size()) begin
            n_bad++;
            $display("FAIL basic_count: got %0d expected %0d", n, exp_src.size());
        end
        for (int i = 0; i < exp_src.size(); i++) begin
            if (i < n) begin
                n_cmp++;
                if (mon_src[sn+i] !== exp_src[i] || mon_dst[sn+i] !== exp_dst[i] || mon_len[sn+i] !== exp_len[i]) begin
                    n_bad++;
                    $display("FAIL basic_xfer[%0d]: got src=%h dst=%h len=%0d expected src=%h dst=%h len=%0d",
                             i, mon_src[sn+i], mon_dst[sn+i], mon_len[sn+i], exp_src[i], exp_dst[i], exp_len[i]);
                end
            end
            if (i > 0 && i < n) begin
                n_cmp++;
                if (mon_cyc[sn+i] - mon_cyc[sn+i-1] != lat + 3) begin
                    n_bad++;
                    $display("FAIL basic_spacing[%0d]: got %0d expected %0d", i, mon_cyc[sn+i] - mon_cyc[sn+i-1], lat + 3);
                end
            end
        end
        if (n > 0) begin
            n_cmp++;
            if (mon_cyc[sn] - s != 2) begin
                n_bad++;
                $display("FAIL basic_first_latency: got %0d expected 2", mon_cyc[sn] - s);
            end
        end
        n_cmp++;
        if (done_cnt - sd != 1 || busy !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_end: got done_cnt=%0d busy=%b error=%b expected 1 0 0", done_cnt - sd, busy, error);
        end
    endtask

    task automatic test_zero_dims();
        int sn, sd, sb, s;
        for (int z = 0; z < 3; z++) begin
            set_cfg(32'h100, 32'h200, (z == 0) ? 16'd0 : 16'd16, (z == 1) ? 10'd0 : 10'd2,
                    (z == 2) ? 10'd0 : 10'd2, 32'h4, 32'h8);
            sn = mon_src.size();
            sd = done_cnt;
            sb = busy_cnt;
            pulse_start(s);
            repeat (6) tick();
            n_cmp++;
            if (mon_src.size() != sn) begin
                n_bad++;
                $display("FAIL zero_dim%0d_starts: got %0d expected 0", z, mon_src.size() - sn);
            end
            n_cmp++;
            if (done_cnt - sd != 1 || done_cyc - s != 2) begin
                n_bad++;
                $display("FAIL zero_dim%0d_done: got count=%0d delay=%0d expected 1 2", z, done_cnt - sd, done_cyc - s);
            end
            n_cmp++;
            if (busy_cnt - sb != 2) begin
                n_bad++;
                $display("FAIL zero_dim%0d_busy: got %0d expected 2", z, busy_cnt - sb);
            end
        end
    endtask

    task automatic test_start_during_wait();
        int sn, sd, s, n, k;
        bit ok;
        set_cfg(32'h4000, 32'h9000, 16'd8, 10'd3, 10'd1, 32'h40, 32'h0);
        lat = 5;
        build_expected();
        sn = mon_src.size();
        sd = done_cnt;
        pulse_start(s);
        k = 0;
        while (mon_src.size() == sn && k < 50) begin
            tick();
            k++;
        end
        // new config and start while the first transfer is outstanding
        set_cfg(32'hAAAA0000, 32'h5555_0000, 16'd3, 10'd5, 10'd4, 32'h10, 32'h20);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(sd, ok);
        repeat (12) tick();
        n = mon_src.size() - sn;
        n_cmp++;
        if (!ok || n != exp_src.size() || done_cnt - sd != 1) begin
            n_bad++;
            $display("FAIL wait_start_count: got xfers=%0d dones=%0d expected %0d 1", n, done_cnt - sd, exp_src.size());
        end
        for (int i = 0; i < exp_src.size(); i++) begin
            if (i < n) begin
                n_cmp++;
                if (mon_src[sn+i] !== exp_src[i] || mon_dst[sn+i] !== exp_dst[i] || mon_len[sn+i] !== exp_len[i]) begin
                    n_bad++;
                    $display("FAIL wait_start_xfer[%0d]: got src=%h dst=%h len=%0d expected src=%h dst=%h len=%0d",
                             i, mon_src[sn+i], mon_dst[sn+i], mon_len[sn+i], exp_src[i], exp_dst[i], exp_len[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int sn, sd, s;
        bit ok;
        set_cfg(32'hFFFF_FF00, 32'h0, 16'd4, 10'd2, 10'd1, 32'h100, 32'h0);
        lat = 2;
        sn = mon_src.size();
        sd = done_cnt;
        pulse_start(s);
        wait_done(sd, ok);
        tick();
        n_cmp++;
        if (!ok || mon_src.size() - sn != 2) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d expected 2", mon_src.size() - sn);
        end else begin
            n_cmp++;
            if (mon_src[sn] !== 32'hFFFF_FF00 || mon_src[sn+1] !== 32'h0 || mon_dst[sn+1] !== 32'h10) begin
                n_bad++;
                $display("FAIL wrap_addr: got src0=%h src1=%h dst1=%h expected ffffff00 00000000 00000010",
                         mon_src[sn], mon_src[sn+1], mon_dst[sn+1]);
            end
        end
    endtask

    task automatic test_random_tiles();
        int sn, sd, s, n;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            set_cfg(32'($urandom), 32'($urandom), 16'($urandom_range(0, 40)), 10'($urandom_range(1, 3)),
                    10'($urandom_range(1, 3)), 32'($urandom), 32'($urandom));
            lat = int'($urandom_range(1, 6));
            build_expected();
            sn = mon_src.size();
            sd = done_cnt;
            pulse_start(s);
            wait_done(sd, ok);
            repeat (3) tick();
            n = mon_src.size() - sn;
            n_cmp++;
            if (!ok || n != exp_src.size() || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_count: got xfers=%0d busy=%b expected %0d 0", it, n, busy, exp_src.size());
            end
            for (int i = 0; i < exp_src.size(); i++) begin
                if (i < n) begin
                    n_cmp++;
                    if (mon_src[sn+i] !== exp_src[i] || mon_dst[sn+i] !== exp_dst[i] || mon_len[sn+i] !== exp_len[i]) begin
                        n_bad++;
                        $display("FAIL rand%0d_xfer[%0d]: got src=%h dst=%h len=%0d expected src=%h dst=%h len=%0d",
                                 it, i, mon_src[sn+i], mon_dst[sn+i], mon_len[sn+i], exp_src[i], exp_dst[i], exp_len[i]);
                    end
                end
                if (i > 0 && i < n) begin
                    n_cmp++;
                    if (mon_cyc[sn+i] - mon_cyc[sn+i-1] != lat + 3) begin
                        n_bad++;
                        $display("FAIL rand%0d_spacing[%0d]: got %0d expected %0d", it, i, mon_cyc[sn+i] - mon_cyc[sn+i-1], lat + 3);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int sn, sd, s, n, k;
        bit ok;
        logic [84:0] obs;
        set_cfg(32'h1000, 32'h8000, 16'd16, 10'd2, 10'd2, 32'h100, 32'h1000);
        lat = 4;
        build_expected();
        sn = mon_src.size();
        pulse_start(s);
        k = 0;
        while (mon_src.size() < sn + 2 && k < 100) begin
            tick();
            k++;
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        tick();
        obs = {src_addr, dst_addr, trans_len, CDMA_start, busy, done, error};
        n_cmp++;
        if (k >= 100 || obs !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h expected 0", obs);
        end
        sn = mon_src.size();
        sd = done_cnt;
        repeat (20) tick();
        n_cmp++;
        if (mon_src.size() != sn || done_cnt != sd) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: got xfers=%0d dones=%0d expected 0 0", mon_src.size() - sn, done_cnt - sd);
        end
        pulse_start(s);
        wait_done(sd, ok);
        tick();
        n = mon_src.size() - sn;
        n_cmp++;
        if (!ok || n != exp_src.size()) begin
            n_bad++;
            $display("FAIL reset_mid_rerun: got %0d expected %0d", n, exp_src.size());
        end
        for (int i = 0; i < exp_src.size(); i++) begin
            if (i < n) begin
                n_cmp++;
                if (mon_src[sn+i] !== exp_src[i] || mon_dst[sn+i] !== exp_dst[i]) begin
                    n_bad++;
                    $display("FAIL reset_mid_xfer[%0d]: got src=%h dst=%h expected src=%h dst=%h",
                             i, mon_src[sn+i], mon_dst[sn+i], exp_src[i], exp_dst[i]);
                end
            end
        end
    endtask

`ifdef CDMA_TIMEOUT_EN
    task automatic test_timeout();
        int sd, s;
        bit ok;
        withhold = 1'b1;
        set_cfg(32'h100, 32'h200, 16'd4, 10'd1, 10'd1, 32'h0, 32'h0);
        sd = done_cnt;
        pulse_start(s);
        wait_done(sd, ok);
        n_cmp++;
        if (!ok || done_cyc - s != 11 || error !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_fire: got delay=%0d error=%b expected 11 1", done_cyc - s, error);
        end
        repeat (4) tick();
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_sticky: got error=%b busy=%b expected 1 0", error, busy);
        end
        withhold = 1'b0;
        lat = 3;
        sd = done_cnt;
        pulse_start(s);
        tick();
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got error=%b expected 0", error);
        end
        wait_done(sd, ok);
        n_cmp++;
        if (!ok || error !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_recover: got done=%b error=%b expected 1 0", ok, error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_tile();
        test_zero_dims();
        test_start_during_wait();
        test_wrap();
        test_random_tiles();
        test_reset_mid();
`ifdef CDMA_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
